// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite list builder and per-pixel owner lookup
// Walks the entity table during hblank, commits the next line's list, then resolves DrawX owners.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 32,
    parameter int MAX_ACTIVE  = 8,
    parameter int COORD_W     = 10,
    parameter int V_LAST      = 524,
    localparam int IDX_W      = $clog2(NUM_SPRITES)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               line_start,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic [IDX_W-1:0]   ent_idx,
    input  logic               ent_valid,
    input  logic [COORD_W-1:0] ent_TLX,
    input  logic [COORD_W-1:0] ent_TLY,
    input  logic [COORD_W-1:0] ent_BRX,
    input  logic [COORD_W-1:0] ent_BRY,
    output logic               sprite_on,
    output logic [IDX_W-1:0]   sprite_id,
    output logic               scan_busy,
    output logic               overflow
);

    localparam int CNT_W = $clog2(MAX_ACTIVE + 1);

    typedef enum logic [0:0] {S_IDLE, S_SCAN} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   target_q, target_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [IDX_W-1:0]     b_idx_q [MAX_ACTIVE];
    logic [IDX_W-1:0]     b_idx_d [MAX_ACTIVE];
    logic [COORD_W-1:0]   b_tlx_q [MAX_ACTIVE];
    logic [COORD_W-1:0]   b_tlx_d [MAX_ACTIVE];
    logic [COORD_W-1:0]   b_brx_q [MAX_ACTIVE];
    logic [COORD_W-1:0]   b_brx_d [MAX_ACTIVE];
    logic [IDX_W-1:0]     d_idx_q [MAX_ACTIVE];
    logic [IDX_W-1:0]     d_idx_d [MAX_ACTIVE];
    logic [COORD_W-1:0]   d_tlx_q [MAX_ACTIVE];
    logic [COORD_W-1:0]   d_tlx_d [MAX_ACTIVE];
    logic [COORD_W-1:0]   d_brx_q [MAX_ACTIVE];
    logic [COORD_W-1:0]   d_brx_d [MAX_ACTIVE];
    logic [CNT_W-1:0]     d_cnt_q, d_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 sprite_on_q, sprite_on_d;
    logic [IDX_W-1:0]     sprite_id_q, sprite_id_d;
    logic                 hit;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        ovf_pend_d  = ovf_pend_q;
        b_idx_d     = b_idx_q;
        b_tlx_d     = b_tlx_q;
        b_brx_d     = b_brx_q;
        d_idx_d     = d_idx_q;
        d_tlx_d     = d_tlx_q;
        d_brx_d     = d_brx_q;
        d_cnt_d     = d_cnt_q;
        overflow_d  = overflow_q;
        sprite_on_d = 1'b0;
        sprite_id_d = '0;
        hit = ent_valid && (ent_TLY <= target_q) && (target_q < ent_BRY);

        // A pulse in either state (re)starts the walk; an aborted walk commits nothing.
        if (line_start) begin
            target_d   = (DrawY == COORD_W'(V_LAST)) ? '0 : DrawY + COORD_W'(1);
            idx_d      = '0;
            bcnt_d     = '0;
            ovf_pend_d = 1'b0;
            state_d    = S_SCAN;
        end else if (state_q == S_SCAN) begin
            if (hit) begin
                if (bcnt_q < CNT_W'(MAX_ACTIVE)) begin
                    for (int k = 0; k < MAX_ACTIVE; k++) begin
                        if (CNT_W'(k) == bcnt_q) begin
                            b_idx_d[k] = idx_q;
                            b_tlx_d[k] = ent_TLX;
                            b_brx_d[k] = ent_BRX;
                        end
                    end
                    bcnt_d = bcnt_q + CNT_W'(1);
                end else begin
                    ovf_pend_d = 1'b1;
                end
            end
            if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                d_idx_d    = b_idx_d;
                d_tlx_d    = b_tlx_d;
                d_brx_d    = b_brx_d;
                d_cnt_d    = bcnt_d;
                overflow_d = ovf_pend_d;
                state_d    = S_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Descending scan so the lowest matching slot is the last writer.
        for (int k = MAX_ACTIVE - 1; k >= 0; k--) begin
            if ((CNT_W'(k) < d_cnt_q) && (d_tlx_q[k] <= DrawX) && (DrawX < d_brx_q[k])) begin
                sprite_on_d = 1'b1;
                sprite_id_d = d_idx_q[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            target_q    <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            ovf_pend_q  <= 1'b0;
            b_idx_q     <= '{default: '0};
            b_tlx_q     <= '{default: '0};
            b_brx_q     <= '{default: '0};
            d_idx_q     <= '{default: '0};
            d_tlx_q     <= '{default: '0};
            d_brx_q     <= '{default: '0};
            d_cnt_q     <= '0;
            overflow_q  <= 1'b0;
            sprite_on_q <= 1'b0;
            sprite_id_q <= '0;
        end else begin
            target_q    <= target_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            ovf_pend_q  <= ovf_pend_d;
            b_idx_q     <= b_idx_d;
            b_tlx_q     <= b_tlx_d;
            b_brx_q     <= b_brx_d;
            d_idx_q     <= d_idx_d;
            d_tlx_q     <= d_tlx_d;
            d_brx_q     <= d_brx_d;
            d_cnt_q     <= d_cnt_d;
            overflow_q  <= overflow_d;
            sprite_on_q <= sprite_on_d;
            sprite_id_q <= sprite_id_d;
        end
    end

    assign ent_idx   = idx_q;
    assign scan_busy = (state_q == S_SCAN);
    assign overflow  = overflow_q;
    assign sprite_on = sprite_on_q;
    assign sprite_id = sprite_id_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - self-checking bench for sprite_line_scheduler
module tb_sprite_line_scheduler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       line_start = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [4:0] ent_idx;
    logic       ent_valid;
    logic [9:0] ent_TLX, ent_TLY, ent_BRX, ent_BRY;
    logic       sprite_on;
    logic [4:0] sprite_id;
    logic       scan_busy;
    logic       overflow;

    logic       t_v   [32];
    logic [9:0] t_tlx [32];
    logic [9:0] t_tly [32];
    logic [9:0] t_brx [32];
    logic [9:0] t_bry [32];

    int total = 0;
    int bad   = 0;

    int m_id  [$];
    int m_tlx [$];
    int m_brx [$];
    int m_ovf = 0;

    typedef struct {
        int phase;
        int x;
        int on;
        int id;
    } vec_t;
    vec_t vecs [11];

    sprite_line_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .line_start (line_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .ent_idx    (ent_idx),
        .ent_valid  (ent_valid),
        .ent_TLX    (ent_TLX),
        .ent_TLY    (ent_TLY),
        .ent_BRX    (ent_BRX),
        .ent_BRY    (ent_BRY),
        .sprite_on  (sprite_on),
        .sprite_id  (sprite_id),
        .scan_busy  (scan_busy),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    assign ent_valid = t_v[ent_idx];
    assign ent_TLX   = t_tlx[ent_idx];
    assign ent_TLY   = t_tly[ent_idx];
    assign ent_BRX   = t_brx[ent_idx];
    assign ent_BRY   = t_bry[ent_idx];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            t_v[i] = 1'b0; t_tlx[i] = '0; t_tly[i] = '0; t_brx[i] = '0; t_bry[i] = '0;
        end
    endtask

    task automatic set_ent(input int i, input int tlx, input int brx, input int tly, input int bry);
        t_v[i]   = 1'b1;
        t_tlx[i] = 10'(tlx);
        t_brx[i] = 10'(brx);
        t_tly[i] = 10'(tly);
        t_bry[i] = 10'(bry);
    endtask

    // Reference list: every live entity covering the target line, ascending index, first 8 kept.
    task automatic model_build(input int y);
        int target, hits;
        target = (y == 524) ? 0 : y + 1;
        hits = 0;
        m_id.delete(); m_tlx.delete(); m_brx.delete();
        for (int i = 0; i < 32; i++) begin
            if (t_v[i] && int'(t_tly[i]) <= target && target < int'(t_bry[i])) begin
                hits++;
                if (hits <= 8) begin
                    m_id.push_back(i);
                    m_tlx.push_back(int'(t_tlx[i]));
                    m_brx.push_back(int'(t_brx[i]));
                end
            end
        end
        m_ovf = (hits > 8) ? 1 : 0;
    endtask

    task automatic model_pix(input int x, output int on, output int id);
        on = 0;
        id = 0;
        for (int k = m_id.size() - 1; k >= 0; k--) begin
            if (m_tlx[k] <= x && x < m_brx[k]) begin
                on = 1;
                id = m_id[k];
            end
        end
    endtask

    task automatic pix(input int x, input string name);
        int on, id;
        DrawX = 10'(x);
        tick();
        model_pix(x, on, id);
        chk({name, "_on"}, int'(sprite_on), on);
        chk({name, "_id"}, int'(sprite_id), id);
    endtask

    task automatic walk(input int y);
        DrawY = 10'(y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk("walk_busy", int'(scan_busy), 1);
            chk("walk_idx", int'(ent_idx), c);
            tick();
        end
        chk("walk_done_busy", int'(scan_busy), 0);
        model_build(y);
        chk("walk_overflow", int'(overflow), m_ovf);
    endtask

    initial begin
        vecs[0]  = '{0,  99, 0, 0};
        vecs[1]  = '{0, 100, 1, 5};
        vecs[2]  = '{0, 115, 1, 5};
        vecs[3]  = '{0, 116, 0, 0};
        vecs[4]  = '{1, 189, 0, 0};
        vecs[5]  = '{1, 190, 1, 3};
        vecs[6]  = '{1, 200, 1, 3};
        vecs[7]  = '{1, 209, 1, 3};
        vecs[8]  = '{1, 210, 1, 9};
        vecs[9]  = '{1, 229, 1, 9};
        vecs[10] = '{1, 230, 0, 0};

        clear_table();

        // Reset and quiet period
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        chk("rst_sprite_on", int'(sprite_on), 0);
        chk("rst_sprite_id", int'(sprite_id), 0);
        chk("rst_busy", int'(scan_busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_ent_idx", int'(ent_idx), 0);
        set_ent(5, 100, 116, 40, 56);
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'(98 + i * 2);
            tick();
            chk("idle_sprite_on", int'(sprite_on), 0);
            chk("idle_busy", int'(scan_busy), 0);
        end

        // Single entity, then two overlapping entities
        for (int ph = 0; ph < 2; ph++) begin
            clear_table();
            if (ph == 0) begin
                set_ent(5, 100, 116, 40, 56);
                walk(39);
            end else begin
                set_ent(3, 190, 210, 0, 100);
                set_ent(9, 200, 230, 0, 100);
                walk(50);
            end
            for (int v = 0; v < 11; v++) begin
                if (vecs[v].phase == ph) begin
                    DrawX = 10'(vecs[v].x);
                    tick();
                    chk($sformatf("vec%0d_on", v), int'(sprite_on), vecs[v].on);
                    chk($sformatf("vec%0d_id", v), int'(sprite_id), vecs[v].id);
                end
            end
        end

        // Ten hits overflow the eight slots
        clear_table();
        for (int i = 0; i < 10; i++) set_ent(i, i * 20, i * 20 + 15, 0, 480);
        walk(10);
        chk("ovf10_flag", int'(overflow), 1);
        for (int x = 0; x < 200; x += 3) pix(x, "ovf10_pix");
        DrawX = 10'd165;
        tick();
        chk("ovf10_dropped8", int'(sprite_on), 0);
        for (int i = 2; i < 10; i++) t_v[i] = 1'b0;
        walk(11);
        chk("two_hits_ovf", int'(overflow), 0);
        for (int i = 2; i < 8; i++) t_v[i] = 1'b1;
        walk(12);
        chk("eight_hits_ovf", int'(overflow), 0);
        DrawX = 10'd145;
        tick();
        chk("eight_hits_on", int'(sprite_on), 1);
        chk("eight_hits_id", int'(sprite_id), 7);

        // Last line wraps to line 0; degenerate boxes never hit
        clear_table();
        set_ent(0, 50, 60, 0, 8);
        set_ent(2, 70, 80, 525, 530);
        set_ent(4, 90, 90, 0, 8);
        set_ent(6, 100, 110, 8, 2);
        walk(524);
        DrawX = 10'd55;  tick();
        chk("wrap_on", int'(sprite_on), 1);
        chk("wrap_id", int'(sprite_id), 0);
        DrawX = 10'd75;  tick();
        chk("wrap_525_unused", int'(sprite_on), 0);
        DrawX = 10'd90;  tick();
        chk("empty_x_box", int'(sprite_on), 0);
        DrawX = 10'd105; tick();
        chk("inverted_y_box", int'(sprite_on), 0);

        // Restart mid-walk: old list stays until the second walk commits
        clear_table();
        set_ent(1, 300, 320, 100, 110);
        set_ent(2, 400, 420, 200, 210);
        DrawX = 10'd55;
        DrawY = 10'd100;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (10) tick();
        DrawY = 10'd200;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int c = 1; c < 32; c++) begin
            tick();
            chk("abort_busy", int'(scan_busy), 1);
            chk("abort_old_on", int'(sprite_on), 1);
            chk("abort_old_id", int'(sprite_id), 0);
        end
        tick();
        chk("abort_commit_busy", int'(scan_busy), 0);
        model_build(200);
        DrawX = 10'd410; tick();
        chk("abort_new_on", int'(sprite_on), 1);
        chk("abort_new_id", int'(sprite_id), 2);
        DrawX = 10'd310; tick();
        chk("abort_first_target", int'(sprite_on), 0);

        // Reset mid-walk clears the display list
        DrawX = 10'd410;
        DrawY = 10'd200;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (10) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_id.delete(); m_tlx.delete(); m_brx.delete();
        chk("midrst_busy", int'(scan_busy), 0);
        chk("midrst_idx", int'(ent_idx), 0);
        chk("midrst_on", int'(sprite_on), 0);
        repeat (40) tick();
        chk("midrst_idle_busy", int'(scan_busy), 0);
        chk("midrst_list_empty", int'(sprite_on), 0);

        // Randomized tables against the reference model
        for (int it = 0; it < 20; it++) begin
            int y;
            clear_table();
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int tly, tlx;
                    tly = $urandom_range(0, 60);
                    tlx = $urandom_range(0, 600);
                    set_ent(i, tlx, tlx + $urandom_range(0, 80), tly, tly + $urandom_range(0, 40));
                    if ($urandom_range(0, 7) == 0) begin
                        t_tlx[i] = 10'(tlx + 5);
                        t_brx[i] = 10'(tlx);
                    end
                end
            end
            y = ($urandom_range(0, 9) == 0) ? 524 : $urandom_range(0, 80);
            walk(y);
            for (int j = 0; j < 16; j++) pix($urandom_range(0, 700), "rand_pix");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
